// File: rtl/hanoi_engine_if.sv
// Move-request and status bundle for the Tower-of-Hanoi engine.
// The engine takes the slave side; a driver or testbench takes the master side.
interface hanoi_engine_if #(
    parameter int N_DISKS = 4,
    parameter int CNT_W   = 16
);
    logic               mv_valid;
    logic               mv_ready;
    logic [1:0]         mv_from;
    logic [1:0]         mv_to;
    logic               auto_start;
    logic [N_DISKS-1:0] peg0;
    logic [N_DISKS-1:0] peg1;
    logic [N_DISKS-1:0] peg2;
    logic               mv_done;
    logic               mv_err;
    logic [1:0]         err_code;
    logic [CNT_W-1:0]   move_cnt;
    logic               busy;
    logic               solved;

    modport master (
        output mv_valid, mv_from, mv_to, auto_start,
        input  mv_ready, peg0, peg1, peg2, mv_done, mv_err, err_code,
               move_cnt, busy, solved
    );

    modport slave (
        input  mv_valid, mv_from, mv_to, auto_start,
        output mv_ready, peg0, peg1, peg2, mv_done, mv_err, err_code,
               move_cnt, busy, solved
    );
endinterface

// File: rtl/hanoi_engine.sv
// Tower-of-Hanoi engine: legality-checked manual moves plus an auto-solver
// that plays the optimal sequence one move per clock.
module hanoi_engine #(
    parameter int N_DISKS = 4,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    hanoi_engine_if.slave   io_bus
);

    typedef enum logic {IDLE, AUTO} state_t;

    localparam logic [N_DISKS-1:0] ALL_ONES = {N_DISKS{1'b1}};
    localparam bit                 ODD_N    = (N_DISKS % 2) == 1;

    state_t             r_state;
    logic [N_DISKS-1:0] r_pegs [3];
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               r_err;
    logic [1:0]         r_errCode;
    logic               r_busy;
    logic               r_solved;
    logic               r_phase;

    logic [N_DISKS-1:0] w_pegView [4];
    logic [1:0]         w_zeroPeg;
    logic [1:0]         w_peerA;
    logic [1:0]         w_peerB;
    logic [N_DISKS-1:0] w_aTop;
    logic [N_DISKS-1:0] w_bTop;
    logic [1:0]         w_autoFrom;
    logic [1:0]         w_autoTo;
    logic [1:0]         w_from;
    logic [1:0]         w_to;
    logic [N_DISKS-1:0] w_src;
    logic [N_DISKS-1:0] w_dst;
    logic [N_DISKS-1:0] w_srcTop;
    logic [N_DISKS-1:0] w_dstTop;
    logic [1:0]         w_code;
    logic               w_legal;
    logic               w_apply;
    logic [N_DISKS-1:0] w_next [3];

    // Peg index 3 reads as an empty peg so out-of-range requests index safely.
    assign w_pegView[0] = r_pegs[0];
    assign w_pegView[1] = r_pegs[1];
    assign w_pegView[2] = r_pegs[2];
    assign w_pegView[3] = '0;

    always_comb begin
        w_zeroPeg = 2'd0;
        if (r_pegs[1][0])
            w_zeroPeg = 2'd1;
        else if (r_pegs[2][0])
            w_zeroPeg = 2'd2;

        case (w_zeroPeg)
            2'd0:    begin w_peerA = 2'd1; w_peerB = 2'd2; end
            2'd1:    begin w_peerA = 2'd0; w_peerB = 2'd2; end
            default: begin w_peerA = 2'd0; w_peerB = 2'd1; end
        endcase

        w_aTop = w_pegView[w_peerA] & (-w_pegView[w_peerA]);
        w_bTop = w_pegView[w_peerB] & (-w_pegView[w_peerB]);

        // Odd towers cycle disk 0 backwards so the stack finishes on peg 2.
        if (!r_phase) begin
            w_autoFrom = w_zeroPeg;
            if (ODD_N)
                w_autoTo = (w_zeroPeg == 2'd0) ? 2'd2 : (w_zeroPeg == 2'd2) ? 2'd1 : 2'd0;
            else
                w_autoTo = (w_zeroPeg == 2'd0) ? 2'd1 : (w_zeroPeg == 2'd1) ? 2'd2 : 2'd0;
        end else if (w_aTop == '0 || (w_bTop != '0 && w_bTop < w_aTop)) begin
            w_autoFrom = w_peerB;
            w_autoTo   = w_peerA;
        end else begin
            w_autoFrom = w_peerA;
            w_autoTo   = w_peerB;
        end
    end

    always_comb begin
        w_from   = (r_state == AUTO) ? w_autoFrom : io_bus.mv_from;
        w_to     = (r_state == AUTO) ? w_autoTo   : io_bus.mv_to;
        w_src    = w_pegView[w_from];
        w_dst    = w_pegView[w_to];
        w_srcTop = w_src & (-w_src);
        w_dstTop = w_dst & (-w_dst);

        // Comparing one-hot tops as numbers compares the disk indices.
        w_legal = 1'b0;
        w_code  = 2'd3;
        if (w_from == 2'd3 || w_to == 2'd3 || w_from == w_to)
            w_code = 2'd3;
        else if (w_src == '0)
            w_code = 2'd1;
        else if (w_dst != '0 && w_srcTop > w_dstTop)
            w_code = 2'd2;
        else begin
            w_code  = 2'd0;
            w_legal = 1'b1;
        end

        w_apply = (r_state == AUTO) ? w_legal
                : (!io_bus.auto_start && io_bus.mv_valid && w_legal);

        for (int p = 0; p < 3; p++) begin
            w_next[p] = r_pegs[p];
            if (2'(p) == w_from)
                w_next[p] = w_next[p] & ~w_srcTop;
            if (2'(p) == w_to)
                w_next[p] = w_next[p] | w_srcTop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pegs[0] <= ALL_ONES;
            r_pegs[1] <= '0;
            r_pegs[2] <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_errCode <= 2'd0;
            r_busy    <= 1'b0;
            r_solved  <= 1'b0;
            r_phase   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_apply) begin
                for (int p = 0; p < 3; p++)
                    r_pegs[p] <= w_next[p];
                r_done   <= 1'b1;
                r_solved <= (w_next[2] == ALL_ONES);
                if (r_cnt != '1)
                    r_cnt <= r_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (io_bus.auto_start) begin
                        if (r_pegs[0] == ALL_ONES) begin
                            r_state <= AUTO;
                            r_busy  <= 1'b1;
                            r_phase <= 1'b0;
                        end else begin
                            r_err     <= 1'b1;
                            r_errCode <= 2'd0;
                        end
                    end else if (io_bus.mv_valid && !w_legal) begin
                        r_err     <= 1'b1;
                        r_errCode <= w_code;
                    end
                end
                AUTO: begin
                    r_phase <= ~r_phase;
                    if (w_next[2] == ALL_ONES) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Structural invariants of the puzzle; ignored by synthesis.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((r_pegs[0] & r_pegs[1]) == '0 && (r_pegs[0] & r_pegs[2]) == '0
                    && (r_pegs[1] & r_pegs[2]) == '0);
            assert ((r_pegs[0] | r_pegs[1] | r_pegs[2]) == ALL_ONES);
            assert (!(r_done && r_err));
            if (r_state == AUTO)
                assert (w_legal);
        end
    end

    assign io_bus.mv_ready = (r_state == IDLE) && !rst;
    assign io_bus.peg0     = r_pegs[0];
    assign io_bus.peg1     = r_pegs[1];
    assign io_bus.peg2     = r_pegs[2];
    assign io_bus.mv_done  = r_done;
    assign io_bus.mv_err   = r_err;
    assign io_bus.err_code = r_errCode;
    assign io_bus.move_cnt = r_cnt;
    assign io_bus.busy     = r_busy;
    assign io_bus.solved   = r_solved;

endmodule

// File: tb/tb_hanoi_engine.sv
// Scoreboarded bench for hanoi_engine: 4-disk and 3-disk engines against a
// bit-vector puzzle model, plus a 2-bit counter instance for saturation.
module tb_hanoi_engine;

    typedef struct {
        logic        isErr;
        logic [1:0]  code;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] cnt;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hanoi_engine_if #(.N_DISKS(4), .CNT_W(16)) b4 ();
    hanoi_engine_if #(.N_DISKS(3), .CNT_W(16)) b3 ();
    hanoi_engine_if #(.N_DISKS(4), .CNT_W(2))  bc ();

    hanoi_engine #(.N_DISKS(4), .CNT_W(16)) dut4 (.clk(clk), .rst(rst), .io_bus(b4.slave));
    hanoi_engine #(.N_DISKS(3), .CNT_W(16)) dut3 (.clk(clk), .rst(rst), .io_bus(b3.slave));
    hanoi_engine #(.N_DISKS(4), .CNT_W(2))  dutC (.clk(clk), .rst(rst), .io_bus(bc.slave));

    int checks = 0;
    int errors = 0;

    expT q4[$];
    expT q3[$];
    logic [15:0] mPeg [2][3];
    int          mCnt [2];
    int          mN   [2] = '{4, 3};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowIdx(input logic [15:0] v);
        for (int i = 0; i < 16; i++)
            if (v[i]) return i;
        return 99;
    endfunction

    task automatic modelReset(input int d);
        mPeg[d][0] = 16'((1 << mN[d]) - 1);
        mPeg[d][1] = '0;
        mPeg[d][2] = '0;
        mCnt[d]    = 0;
    endtask

    task automatic pushEntry(input int d, input logic isErr, input logic [1:0] code);
        expT e;
        e.isErr = isErr;
        e.code  = code;
        e.p0    = mPeg[d][0];
        e.p1    = mPeg[d][1];
        e.p2    = mPeg[d][2];
        e.cnt   = 16'(mCnt[d]);
        if (d == 0) q4.push_back(e);
        else        q3.push_back(e);
    endtask

    // Model a move request: rejection code or updated pegs, then queue it.
    task automatic pushMove(input int d, input int f, input int t);
        int          si;
        int          di;
        logic [15:0] diskBit;
        if (f == 3 || t == 3 || f == t)
            pushEntry(d, 1'b1, 2'd3);
        else if (mPeg[d][f] == 0)
            pushEntry(d, 1'b1, 2'd1);
        else begin
            si = lowIdx(mPeg[d][f]);
            di = lowIdx(mPeg[d][t]);
            if (mPeg[d][t] != 0 && si > di)
                pushEntry(d, 1'b1, 2'd2);
            else begin
                diskBit    = 16'd1 << si;
                mPeg[d][f] = mPeg[d][f] & ~diskBit;
                mPeg[d][t] = mPeg[d][t] | diskBit;
                mCnt[d]++;
                pushEntry(d, 1'b0, 2'd0);
            end
        end
    endtask

    // Closed-form optimal sequence; even towers swap pegs 1 and 2 to end on peg 2.
    task automatic genAuto(input int d);
        int f;
        int t;
        for (int m = 1; m < (1 << mN[d]); m++) begin
            f = (m & (m - 1)) % 3;
            t = ((m | (m - 1)) + 1) % 3;
            if (mN[d] % 2 == 0) begin
                f = (f == 0) ? 0 : 3 - f;
                t = (t == 0) ? 0 : 3 - t;
            end
            pushMove(d, f, t);
        end
    endtask

    task automatic resetAll();
        rst = 1'b1;
        step();
        q4.delete();
        q3.delete();
        modelReset(0);
        modelReset(1);
        step();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int f, input int t);
        b4.mv_valid = 1'b1;
        b4.mv_from  = 2'(f);
        b4.mv_to    = 2'(t);
        pushMove(0, f, t);
        step();
        b4.mv_valid = 1'b0;
        step();
    endtask

    task automatic startAuto(input int d);
        if (mPeg[d][0] == 16'((1 << mN[d]) - 1)) genAuto(d);
        else                                     pushEntry(d, 1'b1, 2'd0);
        if (d == 0) b4.auto_start = 1'b1;
        else        b3.auto_start = 1'b1;
        step();
        b4.auto_start = 1'b0;
        b3.auto_start = 1'b0;
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 64 && ((d == 0) ? q4.size() : q3.size()) != 0; i++)
            step();
        checkOutput("sb_drain", (d == 0) ? q4.size() : q3.size(), 0);
    endtask

    task automatic compareOut(input string pfx, input expT e, input logic err, input logic [1:0] code,
                              input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                              input logic [31:0] cnt);
        checkOutput({pfx, "_kind"}, err, e.isErr);
        if (e.isErr) checkOutput({pfx, "_code"}, code, e.code);
        checkOutput({pfx, "_peg0"}, p0, e.p0);
        checkOutput({pfx, "_peg1"}, p1, e.p1);
        checkOutput({pfx, "_peg2"}, p2, e.p2);
        checkOutput({pfx, "_cnt"}, cnt, e.cnt);
    endtask

    always @(negedge clk) begin
        if (!rst && (b4.mv_done || b4.mv_err)) begin
            checkOutput("d4_done_err_excl", b4.mv_done & b4.mv_err, 0);
            checkOutput("d4_sb_pending", q4.size() != 0, 1);
            if (q4.size() != 0)
                compareOut("d4", q4.pop_front(), b4.mv_err, b4.err_code,
                           b4.peg0, b4.peg1, b4.peg2, b4.move_cnt);
        end
    end

    always @(negedge clk) begin
        if (!rst && (b3.mv_done || b3.mv_err)) begin
            checkOutput("d3_done_err_excl", b3.mv_done & b3.mv_err, 0);
            checkOutput("d3_sb_pending", q3.size() != 0, 1);
            if (q3.size() != 0)
                compareOut("d3", q3.pop_front(), b3.mv_err, b3.err_code,
                           b3.peg0, b3.peg1, b3.peg2, b3.move_cnt);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busyCycles;
        int cMoves [5][2] = '{'{0, 1}, '{0, 2}, '{1, 2}, '{0, 1}, '{2, 0}};
        b4.mv_valid = 1'b0; b4.mv_from = 2'd0; b4.mv_to = 2'd0; b4.auto_start = 1'b0;
        b3.mv_valid = 1'b0; b3.mv_from = 2'd0; b3.mv_to = 2'd0; b3.auto_start = 1'b0;
        bc.mv_valid = 1'b0; bc.mv_from = 2'd0; bc.mv_to = 2'd0; bc.auto_start = 1'b0;

        resetAll();
        @(negedge clk);
        checkOutput("rst_peg0", b4.peg0, 4'hF);
        checkOutput("rst_peg1", b4.peg1, 0);
        checkOutput("rst_peg2", b4.peg2, 0);
        checkOutput("rst_ready", b4.mv_ready, 1);
        checkOutput("rst_cnt", b4.move_cnt, 0);
        checkOutput("rst_solved", b4.solved, 0);
        checkOutput("rst_busy", b4.busy, 0);
        checkOutput("rst_done", b4.mv_done, 0);
        checkOutput("rst_err", b4.mv_err, 0);
        checkOutput("rst_d3_peg0", b3.peg0, 3'h7);
        step();

        applyStimulus(0, 2);
        applyStimulus(0, 2);
        applyStimulus(1, 0);
        applyStimulus(3, 0);
        applyStimulus(1, 1);
        applyStimulus(0, 3);
        applyStimulus(0, 1);
        applyStimulus(2, 1);
        drain(0);

        startAuto(0);
        @(negedge clk);
        checkOutput("auto_reject_busy", b4.busy, 0);
        drain(0);

        resetAll();
        startAuto(0);
        busyCycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b4.busy) busyCycles++;
        end
        drain(0);
        @(negedge clk);
        checkOutput("auto4_busy_cycles", busyCycles, 15);
        checkOutput("auto4_peg2", b4.peg2, 4'hF);
        checkOutput("auto4_solved", b4.solved, 1);
        checkOutput("auto4_cnt", b4.move_cnt, 15);
        checkOutput("auto4_ready", b4.mv_ready, 1);
        step();

        resetAll();
        startAuto(0);
        repeat (5) step();
        rst = 1'b1;
        step();
        q4.delete();
        modelReset(0);
        modelReset(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_peg0", b4.peg0, 4'hF);
        checkOutput("abort_peg2", b4.peg2, 0);
        checkOutput("abort_busy", b4.busy, 0);
        checkOutput("abort_cnt", b4.move_cnt, 0);
        checkOutput("abort_ready", b4.mv_ready, 1);
        step();

        startAuto(1);
        busyCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b3.busy) busyCycles++;
        end
        drain(1);
        @(negedge clk);
        checkOutput("auto3_busy_cycles", busyCycles, 7);
        checkOutput("auto3_peg2", b3.peg2, 3'h7);
        checkOutput("auto3_solved", b3.solved, 1);
        checkOutput("auto3_cnt", b3.move_cnt, 7);
        step();

        for (int k = 0; k < 5; k++) begin
            bc.mv_valid = 1'b1;
            bc.mv_from  = 2'(cMoves[k][0]);
            bc.mv_to    = 2'(cMoves[k][1]);
            step();
            bc.mv_valid = 1'b0;
            @(negedge clk);
            checkOutput("sat_done", bc.mv_done, 1);
            checkOutput("sat_cnt", bc.move_cnt, (k + 1 > 3) ? 3 : k + 1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hanoi_engine.md
Name: hanoi_engine

Overview:
- Parametrised Tower-of-Hanoi puzzle engine for formal and simulation exercises.
- Holds N disks on three pegs and accepts manual move requests over a valid/ready handshake.
- Checks each move for legality. Illegal moves are rejected with an error code and leave the state unchanged.
- Adds an auto-solve mode that plays the optimal 2^N-1 move sequence, one move per cycle, and a move counter.

Parameters:
- N_DISKS, 4, number of disks (2..16). Bit i of a peg vector is disk i; disk 0 is the smallest.
- CNT_W, 16, width of the move counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mv_valid  in  1  manual move request
- mv_ready  out  1  engine can accept a manual move
- mv_from  in  2  source peg (0..2; 3 is invalid)
- mv_to  in  2  destination peg (0..2; 3 is invalid)
- auto_start  in  1  one-cycle pulse requesting auto-solve
- peg0  out  N_DISKS  occupancy of peg 0
- peg1  out  N_DISKS  occupancy of peg 1
- peg2  out  N_DISKS  occupancy of peg 2
- mv_done  out  1  one-cycle pulse: a move was applied
- mv_err  out  1  one-cycle pulse: request rejected
- err_code  out  2  reason for rejection, valid while mv_err is high
- move_cnt  out  CNT_W  number of applied moves, saturating
- busy  out  1  auto-solve in progress
- solved  out  1  peg2 holds all disks

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - peg0 = all ones; peg1 = peg2 = 0.
  - move_cnt = 0; mv_done = mv_err = busy = solved = 0; err_code = 0.
  - FSM = IDLE; mv_ready = 1 after reset.
  - rst during AUTO aborts the solve and restores the initial position.
- Top disk of a peg = its lowest set bit. An empty peg has no top.
- FSM states: IDLE and AUTO.
- mv_ready = (state == IDLE) && !rst.
- Manual move: accepted on a clock edge where mv_valid && mv_ready. It is evaluated combinationally against the current pegs. The same edge either applies it or rejects it:
  - Applied: clear the top bit on the source peg, set it on the destination peg, move_cnt += 1.
  - mv_done is high in the cycle after the edge; pegs show the new state in that same cycle. Latency = 1.
- Rejection rules, in priority order; the first match sets err_code:
  - 3: mv_from == 3, or mv_to == 3, or mv_from == mv_to.
  - 1: source peg is empty.
  - 2: source top index > destination top index, when the destination is non-empty.
- On rejection: pegs and move_cnt are unchanged, and mv_err pulses for 1 cycle.
- mv_done and mv_err are never high together.
- move_cnt saturates at 2^CNT_W-1; it does not wrap.
- auto_start in IDLE:
  - If the position is initial (peg0 all ones), go to AUTO with busy = 1; move_cnt is not cleared.
  - Otherwise pulse mv_err with err_code = 0 and stay in IDLE.
- auto_start in AUTO is ignored.
- If auto_start and mv_valid occur on the same IDLE edge, auto_start wins. The manual request is not accepted and must be held by the master.
- AUTO: one move applied per clock, and mv_done pulses for each move. An internal phase bit starts at 0 and toggles every move.
  - Phase 0: move disk 0 cyclically. For N_DISKS even: 0→1→2→0. For N_DISKS odd: 0→2→1→0.
  - Phase 1: make the unique legal move between the two pegs not holding disk 0. The smaller top moves onto the larger top or onto the empty peg.
- AUTO exit: when peg2 == all ones after an applied move, go to IDLE next cycle with busy = 0. Exactly 2^N_DISKS-1 moves are made.
- solved = (peg2 == all ones), registered with the pegs.
- Invariant, checked with assertions: the three peg vectors are pairwise disjoint, their OR is all ones, and every applied move is legal.

Test Plan:
- Reset, N_DISKS=4 → peg0 = 4'hF, peg1 = peg2 = 0, mv_ready = 1, move_cnt = 0, solved = 0.
- Manual move 0→2 → next cycle peg0 = 4'hE, peg2 = 4'h1, mv_done = 1, move_cnt = 1. Then 0→2 again → mv_err = 1, err_code = 2, pegs unchanged.
- Move from empty peg1 → err_code = 1. Request 3→0 → err_code = 3. Request 1→1 → err_code = 3. move_cnt unchanged throughout.
- auto_start from reset, N_DISKS=4 → busy high for 15 cycles with 15 mv_done pulses; then peg2 = 4'hF, solved = 1, move_cnt = 15, mv_ready = 1. Repeat with N_DISKS=3 → 7 moves, final peg2 = 3'h7.
- auto_start after one manual move → mv_err with err_code = 0, busy stays 0. rst asserted mid-AUTO → initial position, busy = 0, move_cnt = 0.
- CNT_W=2, 5 legal manual moves → move_cnt sticks at 3.
